// File: rtl/sys_cmd_regfile.sv
// Command-bus register file: board ID, error counter, pulse strobe, raw and sticky status, control registers.
// Handshake: IDLE -> ACK (one-cycle ack) -> RELEASE (wait for select low), so a held select is acked once.
module sys_cmd_regfile #(
  parameter logic [7:0] FPGA_UID      = 8'h00,
  parameter int         CMD_DATA_BITS = 32,
  parameter int         CMD_ADDR_BITS = 16,
  parameter int         NUM_CTRL_REGS = 4,
  parameter int         NUM_STAT_CH   = 2
) (
  input  logic                                   i_sysclk,
  input  logic                                   i_srst,
  input  logic                                   i_cmd_sel,
  input  logic                                   i_cmd_rd_wr_n,
  input  logic [CMD_ADDR_BITS-1:0]               i_cmd_byte_addr,
  input  logic [CMD_DATA_BITS-1:0]               i_cmd_wdata,
  output logic [CMD_DATA_BITS-1:0]               o_cmd_rdata,
  output logic                                   o_cmd_ack,
  input  logic [NUM_STAT_CH*CMD_DATA_BITS-1:0]   i_status,
  output logic [NUM_CTRL_REGS*CMD_DATA_BITS-1:0] o_ctrl,
  output logic [CMD_DATA_BITS-1:0]               o_pulse
);
  localparam int           W             = CMD_DATA_BITS;
  localparam logic [63:0]  UNMAPPED_WORD = 64'hDEADBEEF;
  localparam logic [W-1:0] UNMAPPED      = UNMAPPED_WORD[W-1:0];

  typedef enum logic [1:0] {IDLE, ACK, RELEASE} state_t;

  state_t                   state;
  logic                     ack_q;
  logic [15:0]              err_cnt;
  logic [NUM_STAT_CH*W-1:0] sticky;

  logic [3:0]               idx;
  logic                     aligned;
  logic                     rd_ok;
  logic                     wr_ok;
  logic                     mapped;
  logic                     accept;
  logic                     hit_err;
  logic                     hit_pulse;
  logic [NUM_STAT_CH-1:0]   hit_sticky;
  logic [NUM_CTRL_REGS-1:0] hit_ctrl;
  logic [W-1:0]             rd_val;
  logic [NUM_STAT_CH*W-1:0] sticky_clr;

  always_comb begin
    // NOTE: every signal gets a default first, so no path through the decode can infer a latch.
    idx        = i_cmd_byte_addr[5:2];
    aligned    = (i_cmd_byte_addr[1:0] == 2'b00) && ((i_cmd_byte_addr >> 7) == '0);
    rd_ok      = 1'b0;
    wr_ok      = 1'b0;
    hit_err    = 1'b0;
    hit_pulse  = 1'b0;
    hit_sticky = '0;
    hit_ctrl   = '0;
    rd_val     = UNMAPPED;
    sticky_clr = '0;

    if (aligned) begin
      // Regions by addr[6:4]: 0 misc, 1 raw status, 2-3 sticky status, 4-7 control.
      case (i_cmd_byte_addr[6:4])
        3'd0: begin
          case (idx[1:0])
            2'd0: begin
              rd_ok  = 1'b1;
              rd_val = {i_status[W-9:0], FPGA_UID};
            end
            2'd1: begin
              rd_ok   = 1'b1;
              wr_ok   = 1'b1;
              hit_err = 1'b1;
              rd_val  = W'(err_cnt);
            end
            2'd2: begin
              rd_ok     = 1'b1;
              wr_ok     = 1'b1;
              hit_pulse = 1'b1;
              rd_val    = '0;
            end
            default: ;
          endcase
        end
        3'd1: begin
          for (int k = 0; k < NUM_STAT_CH; k++) begin
            if (int'(idx[1:0]) == k) begin
              rd_ok  = 1'b1;
              rd_val = i_status[k*W +: W];
            end
          end
        end
        3'd2, 3'd3: begin
          for (int k = 0; k < NUM_STAT_CH; k++) begin
            if (int'(idx[2:0]) == k) begin
              rd_ok         = 1'b1;
              wr_ok         = 1'b1;
              hit_sticky[k] = 1'b1;
              rd_val        = sticky[k*W +: W];
            end
          end
        end
        default: begin
          for (int n = 0; n < NUM_CTRL_REGS; n++) begin
            if (int'(idx) == n) begin
              rd_ok       = 1'b1;
              wr_ok       = 1'b1;
              hit_ctrl[n] = 1'b1;
              rd_val      = o_ctrl[n*W +: W];
            end
          end
        end
      endcase
    end

    mapped = i_cmd_rd_wr_n ? rd_ok : wr_ok;
    accept = (state == IDLE) && i_cmd_sel;
    for (int k = 0; k < NUM_STAT_CH; k++) begin
      if (accept && !i_cmd_rd_wr_n && hit_sticky[k]) sticky_clr[k*W +: W] = i_cmd_wdata;
    end
  end

  // Reset drops an ack already in flight, so an access interrupted in ACK is never acknowledged.
  assign o_cmd_ack = ack_q & ~i_srst;

  always_ff @(posedge i_sysclk) begin
    if (i_srst) begin
      state       <= IDLE;
      ack_q       <= 1'b0;
      o_cmd_rdata <= '0;
      o_ctrl      <= '0;
      o_pulse     <= '0;
      sticky      <= '0;
      err_cnt     <= '0;
    end else begin
      // NOTE: state is updated with non-blocking assignments only, so every read here sees pre-edge values.
      ack_q   <= 1'b0;
      o_pulse <= '0;
      // Status set is applied after the clear, so a coincident set wins.
      sticky  <= (sticky & ~sticky_clr) | i_status;
      case (state)
        IDLE: begin
          if (accept) begin
            state <= ACK;
            ack_q <= 1'b1;
            if (i_cmd_rd_wr_n) o_cmd_rdata <= rd_val;
            if (!mapped) begin
              if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
            end else if (!i_cmd_rd_wr_n) begin
              if (hit_err)   err_cnt <= '0;
              if (hit_pulse) o_pulse <= i_cmd_wdata;
              for (int n = 0; n < NUM_CTRL_REGS; n++) begin
                if (hit_ctrl[n]) o_ctrl[n*W +: W] <= i_cmd_wdata;
              end
            end
          end
        end
        ACK:     state <= RELEASE;
        RELEASE: if (!i_cmd_sel) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sys_cmd_regfile.sv
// Bench for sys_cmd_regfile: directed and random accesses against a register-map reference model,
// with a scoreboard queue drained by an independent ack monitor.
module tb_sys_cmd_regfile;
  localparam int         NCTRL = 4;
  localparam int         NSTAT = 2;
  localparam logic [7:0] UID   = 8'hA5;

  typedef struct {
    int            cyc;
    logic [31:0]   rdata;
    logic [127:0]  ctrl;
    logic [31:0]   pulse;
  } exp_t;

  logic          clk = 1'b0;
  logic          srst;
  logic          sel;
  logic          rd_wr_n;
  logic [15:0]   addr;
  logic [31:0]   wdata;
  logic [63:0]   status;
  logic [31:0]   rdata;
  logic          ack;
  logic [127:0]  ctrl;
  logic [31:0]   pulse;

  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  bit            rand_status = 1'b0;

  // Reference model state
  logic [31:0]   ctrl_m [NCTRL];
  logic [31:0]   sticky_m [NSTAT];
  int            err_m;
  logic [31:0]   last_rd;
  exp_t          exp_q [$];
  exp_t          mon_e;

  sys_cmd_regfile #(
    .FPGA_UID(UID), .CMD_DATA_BITS(32), .CMD_ADDR_BITS(16),
    .NUM_CTRL_REGS(NCTRL), .NUM_STAT_CH(NSTAT)
  ) dut (
    .i_sysclk(clk), .i_srst(srst), .i_cmd_sel(sel), .i_cmd_rd_wr_n(rd_wr_n),
    .i_cmd_byte_addr(addr), .i_cmd_wdata(wdata), .o_cmd_rdata(rdata), .o_cmd_ack(ack),
    .i_status(status), .o_ctrl(ctrl), .o_pulse(pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic void reset_model();
    for (int n = 0; n < NCTRL; n++) ctrl_m[n] = '0;
    for (int k = 0; k < NSTAT; k++) sticky_m[k] = '0;
    err_m   = 0;
    last_rd = '0;
  endfunction

  function automatic logic [31:0] model_read(input int a, output bit ok);
    ok = 1'b1;
    if (a % 4 != 0)                         begin ok = 1'b0; return 32'hDEADBEEF; end
    if (a == 0)                             return {status[23:0], UID};
    if (a == 4)                             return 32'(err_m);
    if (a == 8)                             return 32'h0;
    if (a >= 'h10 && a < 'h10 + 4*NSTAT)    return status[((a - 'h10) / 4) * 32 +: 32];
    if (a >= 'h20 && a < 'h20 + 4*NSTAT)    return sticky_m[(a - 'h20) / 4];
    if (a >= 'h40 && a < 'h40 + 4*NCTRL)    return ctrl_m[(a - 'h40) / 4];
    ok = 1'b0;
    return 32'hDEADBEEF;
  endfunction

  function automatic bit model_writable(input int a);
    if (a % 4 != 0) return 1'b0;
    return (a == 4) || (a == 8) ||
           (a >= 'h20 && a < 'h20 + 4*NSTAT) ||
           (a >= 'h40 && a < 'h40 + 4*NCTRL);
  endfunction

  // Advance one clock edge, applying what that edge does to the sticky/reset model.
  task automatic step(input logic [63:0] clr);
    if (srst) reset_model();
    else for (int k = 0; k < NSTAT; k++)
      sticky_m[k] = (sticky_m[k] & ~clr[k*32 +: 32]) | status[k*32 +: 32];
    @(posedge clk);
    #1;
    if (rand_status)
      status = ($urandom_range(0, 5) == 0) ? (64'd1 << $urandom_range(0, 63)) : 64'd0;
  endtask

  task automatic access(input bit rd, input int a, input logic [31:0] wd, input int hold,
                        input logic [63:0] st_pulse, input bit abort);
    exp_t        e;
    bit          ok;
    logic [31:0] rv;
    logic [63:0] clr;
    logic [31:0] pe;
    clr     = '0;
    pe      = '0;
    status  = status | st_pulse;
    sel     = 1'b1;
    rd_wr_n = rd;
    addr    = 16'(a);
    wdata   = wd;
    rv = model_read(a, ok);
    if (rd) last_rd = rv;
    else    ok = model_writable(a);
    if (!ok) begin
      if (err_m < 65535) err_m++;
    end else if (!rd) begin
      if (a == 4)                               err_m = 0;
      else if (a == 8)                          pe = wd;
      else if (a >= 'h20 && a < 'h20 + 4*NSTAT) clr[((a - 'h20) / 4) * 32 +: 32] = wd;
      else if (a >= 'h40 && a < 'h40 + 4*NCTRL) ctrl_m[(a - 'h40) / 4] = wd;
    end
    e.cyc   = cyc + 1;
    e.rdata = last_rd;
    e.pulse = pe;
    for (int n = 0; n < NCTRL; n++) e.ctrl[n*32 +: 32] = ctrl_m[n];
    if (!abort) exp_q.push_back(e);
    step(clr);
    status = status & ~st_pulse;
    if (abort) begin
      srst = 1'b1;
      sel  = 1'b0;
      step('0);
      srst = 1'b0;
      step('0);
      return;
    end
    repeat (hold) step('0);
    sel = 1'b0;
    step('0);
    step('0);
  endtask

  // Monitor: every ack must match the oldest expectation; o_pulse must be idle otherwise.
  always @(negedge clk) begin
    if (ack === 1'b1) begin
      check("ack_expected", 128'(exp_q.size() != 0), 128'(1));
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("ack_cycle", 128'(cyc), 128'(mon_e.cyc));
        check("rdata", 128'(rdata), 128'(mon_e.rdata));
        check("ctrl", ctrl, mon_e.ctrl);
        check("pulse", 128'(pulse), 128'(mon_e.pulse));
      end
    end else begin
      check("pulse_idle", 128'(pulse), 128'(0));
    end
  end

  initial begin
    int addr_pool [16] = '{'h00, 'h04, 'h08, 'h0C, 'h10, 'h14, 'h18, 'h20,
                           'h24, 'h28, 'h40, 'h44, 'h48, 'h4C, 'h50, 'h42};
    srst = 1'b1; sel = 1'b0; rd_wr_n = 1'b1; addr = '0; wdata = '0; status = '0;
    reset_model();
    repeat (3) step('0);
    check("reset_ack", 128'(ack), 128'(0));
    check("reset_rdata", 128'(rdata), 128'(0));
    check("reset_ctrl", ctrl, 128'(0));
    check("reset_pulse", 128'(pulse), 128'(0));
    srst = 1'b0;
    step('0);

    // ID register and control read-back with a long-held select
    status = 64'h00000000_00123456;
    access(1'b1, 'h00, '0, 0, '0, 1'b0);
    access(1'b0, 'h44, 32'hCAFEF00D, 4, '0, 1'b0);
    access(1'b1, 'h44, '0, 0, '0, 1'b0);

    // Sticky: set by a pulse, set wins over coincident clear, clear without pulse
    status[35] = 1'b1;
    step('0);
    status[35] = 1'b0;
    access(1'b1, 'h24, '0, 0, '0, 1'b0);
    access(1'b0, 'h24, 32'h8, 0, 64'h8 << 32, 1'b0);
    access(1'b1, 'h24, '0, 0, '0, 1'b0);
    access(1'b0, 'h24, 32'h8, 0, '0, 1'b0);
    access(1'b1, 'h24, '0, 0, '0, 1'b0);

    // Unmapped accesses and the error counter
    access(1'b1, 'h06, '0, 0, '0, 1'b0);
    access(1'b0, 'h80, 32'h1234, 0, '0, 1'b0);
    access(1'b1, 'h04, '0, 0, '0, 1'b0);
    access(1'b0, 'h04, 32'h0, 0, '0, 1'b0);
    access(1'b1, 'h04, '0, 0, '0, 1'b0);
    access(1'b0, 'h00, 32'hFFFF, 0, '0, 1'b0);
    access(1'b0, 'h14, 32'hFFFF, 0, '0, 1'b0);
    access(1'b1, 'h18, '0, 1, '0, 1'b0);
    access(1'b1, 'h04, '0, 0, '0, 1'b0);

    // Pulse register
    access(1'b0, 'h08, 32'h5, 0, '0, 1'b0);
    access(1'b1, 'h08, '0, 0, '0, 1'b0);

    // Random traffic with sparse random status pulses
    rand_status = 1'b1;
    for (int i = 0; i < 80; i++) begin
      int sel_i;
      int a;
      sel_i = $urandom_range(0, 16);
      a = (sel_i == 16) ? int'($urandom_range(0, 65535)) : addr_pool[sel_i];
      access(1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 2), '0, 1'b0);
    end
    rand_status = 1'b0;
    status = '0;

    // Reset during ACK of a control write: no ack, control cleared
    access(1'b0, 'h40, 32'h1111_2222, 0, '0, 1'b0);
    access(1'b0, 'h4C, 32'h3333_4444, 0, '0, 1'b1);
    check("abort_ack_ctrl", ctrl, 128'(0));
    check("abort_ack_rdata", 128'(rdata), 128'(0));

    // Reset coincident with a would-be accept: nothing happens
    access(1'b0, 'h40, 32'h5555_6666, 0, '0, 1'b0);
    srst = 1'b1; sel = 1'b1; rd_wr_n = 1'b0; addr = 16'h0044; wdata = 32'h7777_8888;
    step('0);
    srst = 1'b0; sel = 1'b0;
    step('0);
    step('0);
    check("abort_idle_ctrl", ctrl, 128'(0));
    access(1'b1, 'h44, '0, 0, '0, 1'b0);

    repeat (3) step('0);
    check("missing_acks", 128'(exp_q.size()), 128'(0));
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
